// File: rtl/out_switch_pkg.sv
// out_switch_pkg: shared constants, width helper and lock-FSM state type for out_switch_arb
package out_switch_pkg;
  localparam int REQ_PER_CH = 2;
  typedef enum logic {IDLE, LOCKED} state_e;
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) if ((1 << r) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr_i (wrapping)
// Ports: req_i request vector, ptr_i priority start; grant_o one-hot, idx_o encoded, any_o some request
module rr_arbiter
  import out_switch_pkg::*;
#(
  parameter int N = 6
) (
  input  logic [N-1:0]        req_i,
  input  logic [clog2(N)-1:0] ptr_i,
  output logic [N-1:0]        grant_o,
  output logic [clog2(N)-1:0] idx_o,
  output logic                any_o
);
  localparam int PW = clog2(N);
  always_comb begin
    idx_o = '0;
    // Scan from farthest to nearest so the nearest request at/after ptr wins.
    for (int k = N - 1; k >= 0; k--)
      if (req_i[(int'(ptr_i) + k) % N]) idx_o = PW'((int'(ptr_i) + k) % N);
    any_o = |req_i;
    grant_o = any_o ? N'(1) << idx_o : '0;
  end
endmodule

// File: rtl/out_switch_arb.sv
// out_switch_arb: packet-locked round-robin merge of wide/narrow streams onto registered g and h outputs
// Ports: s_axis_* wide sources, s_axis_256_* narrow sources, m_axis_g_* upper wide bits,
//        m_axis_h_* low wide bits or narrow data plus tlast; clk/rst synchronous active-high
module out_switch_arb
  import out_switch_pkg::*;
#(
  parameter int NUM_CH   = 3,
  parameter int WIDE_W   = 1536,
  parameter int NARROW_W = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*WIDE_W-1:0]     s_axis_tdata,
  input  logic [NUM_CH-1:0]            s_axis_tvalid,
  input  logic [NUM_CH-1:0]            s_axis_tlast,
  output logic [NUM_CH-1:0]            s_axis_tready,
  input  logic [NUM_CH*NARROW_W-1:0]   s_axis_256_tdata,
  input  logic [NUM_CH-1:0]            s_axis_256_tvalid,
  input  logic [NUM_CH-1:0]            s_axis_256_tlast,
  output logic [NUM_CH-1:0]            s_axis_256_tready,
  output logic [WIDE_W-NARROW_W-1:0]   m_axis_g_tdata,
  output logic                         m_axis_g_tvalid,
  input  logic                         m_axis_g_tready,
  output logic [NARROW_W-1:0]          m_axis_h_tdata,
  output logic                         m_axis_h_tvalid,
  input  logic                         m_axis_h_tready,
  output logic                         m_axis_h_tlast
);
  localparam int NR  = REQ_PER_CH * NUM_CH;
  localparam int PW  = clog2(NR);
  localparam int G_W = WIDE_W - NARROW_W;
  state_e state_q, state_d;
  logic [PW-1:0] lock_q, lock_d, ptr_q, ptr_d, arb_idx, gnt, ch;
  logic [NR-1:0] req, lasts, arb_oh, gnt_oh;
  logic arb_any, act, wide, gvld, glast, g_free, h_free, room, acc;
  logic [WIDE_W-1:0] wdata;
  logic [NARROW_W-1:0] ndata;
  logic g_valid_q, g_valid_d, h_valid_q, h_valid_d, h_last_q, h_last_d;
  logic [G_W-1:0] g_data_q, g_data_d;
  logic [NARROW_W-1:0] h_data_q, h_data_d;
  assign req   = {s_axis_256_tvalid, s_axis_tvalid};
  assign lasts = {s_axis_256_tlast, s_axis_tlast};
  rr_arbiter #(.N(NR)) u_arb (
    .req_i  (req),
    .ptr_i  (ptr_q),
    .grant_o(arb_oh),
    .idx_o  (arb_idx),
    .any_o  (arb_any)
  );
  always_comb begin
    gnt    = state_q == LOCKED ? lock_q : arb_idx;
    gnt_oh = state_q == LOCKED ? NR'(1) << lock_q : arb_oh;
    act    = state_q == LOCKED || arb_any;
    wide   = gnt < PW'(NUM_CH);
    ch     = wide ? gnt : gnt - PW'(NUM_CH);
    gvld   = act && |(req & gnt_oh);
    glast  = |(lasts & gnt_oh);
    wdata  = s_axis_tdata[int'(ch)*WIDE_W +: WIDE_W];
    ndata  = s_axis_256_tdata[int'(ch)*NARROW_W +: NARROW_W];
    g_free = !g_valid_q || m_axis_g_tready;
    h_free = !h_valid_q || m_axis_h_tready;
    // A wide beat needs both slots so its two halves always leave together.
    room   = act && !rst && (wide ? g_free && h_free : h_free);
    acc    = room && gvld;
    s_axis_tready     = room && wide ? NUM_CH'(1) << ch : '0;
    s_axis_256_tready = room && !wide ? NUM_CH'(1) << ch : '0;
    state_d = state_q;
    lock_d  = lock_q;
    ptr_d   = ptr_q;
    if (acc) begin
      state_d = glast ? IDLE : LOCKED;
      lock_d  = gnt;
      ptr_d   = glast ? (gnt == PW'(NR - 1) ? '0 : gnt + 1'b1) : ptr_q;
    end
    g_valid_d = (acc && wide) || (g_valid_q && !m_axis_g_tready);
    g_data_d  = acc && wide ? wdata[WIDE_W-1:NARROW_W] : g_data_q;
    h_valid_d = acc || (h_valid_q && !m_axis_h_tready);
    h_data_d  = acc ? (wide ? wdata[NARROW_W-1:0] : ndata) : h_data_q;
    h_last_d  = acc ? glast : h_last_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lock_q    <= '0;
      ptr_q     <= '0;
      g_valid_q <= 1'b0;
      g_data_q  <= '0;
      h_valid_q <= 1'b0;
      h_data_q  <= '0;
      h_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_q    <= lock_d;
      ptr_q     <= ptr_d;
      g_valid_q <= g_valid_d;
      g_data_q  <= g_data_d;
      h_valid_q <= h_valid_d;
      h_data_q  <= h_data_d;
      h_last_q  <= h_last_d;
    end
  end
  assign m_axis_g_tdata  = g_data_q;
  assign m_axis_g_tvalid = g_valid_q;
  assign m_axis_h_tdata  = h_data_q;
  assign m_axis_h_tvalid = h_valid_q;
  assign m_axis_h_tlast  = h_last_q;
endmodule

// File: tb/tb_out_switch_arb.sv
// tb_out_switch_arb: randomized and directed checks of out_switch_arb against a packet-level reference model
module tb_out_switch_arb;
  localparam int NC = 3, WW = 1536, NW = 256, GW = WW - NW, NR = 2 * NC;
  logic clk = 1'b0;
  logic rst;
  logic [NC*WW-1:0] s_axis_tdata;
  logic [NC-1:0] s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [NC*NW-1:0] s_axis_256_tdata;
  logic [NC-1:0] s_axis_256_tvalid, s_axis_256_tlast, s_axis_256_tready;
  logic [GW-1:0] m_axis_g_tdata;
  logic m_axis_g_tvalid, m_axis_g_tready;
  logic [NW-1:0] m_axis_h_tdata;
  logic m_axis_h_tvalid, m_axis_h_tready, m_axis_h_tlast;
  always #5 clk = ~clk;
  out_switch_arb #(.NUM_CH(NC), .WIDE_W(WW), .NARROW_W(NW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .s_axis_256_tdata(s_axis_256_tdata), .s_axis_256_tvalid(s_axis_256_tvalid),
    .s_axis_256_tlast(s_axis_256_tlast), .s_axis_256_tready(s_axis_256_tready),
    .m_axis_g_tdata(m_axis_g_tdata), .m_axis_g_tvalid(m_axis_g_tvalid),
    .m_axis_g_tready(m_axis_g_tready),
    .m_axis_h_tdata(m_axis_h_tdata), .m_axis_h_tvalid(m_axis_h_tvalid),
    .m_axis_h_tready(m_axis_h_tready), .m_axis_h_tlast(m_axis_h_tlast)
  );
  typedef struct {logic [WW-1:0] d; logic l;} beat_t;
  beat_t srcq[NR][$];
  logic [NR-1:0] en;
  bit m_lock, mgv, mhv, mhl;
  int m_idx, m_ptr;
  logic [GW-1:0] mgd;
  logic [NW-1:0] mhd;
  int acc_log[$];
  int errors = 0, checks = 0;
  task automatic model_reset();
    m_lock = 0; m_idx = 0; m_ptr = 0;
    mgv = 0; mhv = 0; mhl = 0; mgd = '0; mhd = '0;
  endtask
  function automatic logic [WW-1:0] rnd_wide();
    logic [WW-1:0] r;
    for (int i = 0; i < WW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  task automatic push_pkt(input int r, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d = rnd_wide();
      b.l = (i == n - 1);
      srcq[r].push_back(b);
    end
  endtask
  task automatic clear_srcs();
    for (int i = 0; i < NR; i++) srcq[i].delete();
  endtask
  function automatic bit srcs_empty();
    for (int i = 0; i < NR; i++) if (srcq[i].size() != 0) return 0;
    return 1;
  endfunction
  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      logic v;
      logic [WW-1:0] d;
      logic l;
      v = en[i] && srcq[i].size() != 0;
      d = '0;
      l = 1'b0;
      if (srcq[i].size() != 0) begin
        d = srcq[i][0].d;
        l = srcq[i][0].l;
      end
      if (i < NC) begin
        s_axis_tvalid[i] = v;
        s_axis_tlast[i] = l;
        s_axis_tdata[i*WW +: WW] = d;
      end else begin
        s_axis_256_tvalid[i-NC] = v;
        s_axis_256_tlast[i-NC] = l;
        s_axis_256_tdata[(i-NC)*NW +: NW] = d[NW-1:0];
      end
    end
  endtask
  // One clock: present source heads, compare DUT against model at negedge, advance model at posedge.
  task automatic step();
    logic [NR-1:0] vreq;
    logic [NC-1:0] ew, en_n;
    int pg;
    bit pany, room, acc;
    beat_t b;
    drive();
    vreq = {s_axis_256_tvalid, s_axis_tvalid};
    @(negedge clk);
    pany = 0;
    pg = 0;
    if (m_lock) begin
      pany = 1;
      pg = m_idx;
    end else begin
      for (int k = 0; k < NR; k++)
        if (!pany && vreq[(m_ptr + k) % NR]) begin
          pany = 1;
          pg = (m_ptr + k) % NR;
        end
    end
    room = pany && !rst && (pg < NC ? (!mgv || m_axis_g_tready) && (!mhv || m_axis_h_tready)
                                    : (!mhv || m_axis_h_tready));
    ew = '0;
    en_n = '0;
    if (room) begin
      if (pg < NC) ew[pg] = 1'b1;
      else en_n[pg-NC] = 1'b1;
    end
    checks += 7;
    if (s_axis_tready !== ew) begin
      errors++; $display("FAIL wide_tready got %b exp %b t=%0t", s_axis_tready, ew, $time);
    end
    if (s_axis_256_tready !== en_n) begin
      errors++; $display("FAIL narrow_tready got %b exp %b t=%0t", s_axis_256_tready, en_n, $time);
    end
    if (m_axis_g_tvalid !== mgv) begin
      errors++; $display("FAIL g_tvalid got %b exp %b t=%0t", m_axis_g_tvalid, mgv, $time);
    end
    if (m_axis_h_tvalid !== mhv) begin
      errors++; $display("FAIL h_tvalid got %b exp %b t=%0t", m_axis_h_tvalid, mhv, $time);
    end
    if (m_axis_g_tdata !== mgd) begin
      errors++; $display("FAIL g_tdata got ..%h exp ..%h t=%0t", m_axis_g_tdata[63:0], mgd[63:0], $time);
    end
    if (m_axis_h_tdata !== mhd) begin
      errors++; $display("FAIL h_tdata got ..%h exp ..%h t=%0t", m_axis_h_tdata[63:0], mhd[63:0], $time);
    end
    if (m_axis_h_tlast !== mhl) begin
      errors++; $display("FAIL h_tlast got %b exp %b t=%0t", m_axis_h_tlast, mhl, $time);
    end
    acc = room && vreq[pg];
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (mgv && m_axis_g_tready) mgv = 0;
      if (mhv && m_axis_h_tready) mhv = 0;
      if (acc) begin
        b = srcq[pg].pop_front();
        acc_log.push_back(pg);
        if (pg < NC) begin
          mgv = 1;
          mgd = b.d[WW-1:NW];
        end
        mhv = 1;
        mhd = b.d[NW-1:0];
        mhl = b.l;
        if (b.l) begin
          m_lock = 0;
          m_ptr = (pg + 1) % NR;
        end else begin
          m_lock = 1;
          m_idx = pg;
        end
      end
    end
    #1;
  endtask
  task automatic drain();
    int n = 0;
    en = '1;
    m_axis_g_tready = 1'b1;
    m_axis_h_tready = 1'b1;
    while ((!srcs_empty() || mgv || mhv) && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++; $display("FAIL drain_timeout got %0d cycles exp <200", n);
    end
  endtask
  task automatic test_reset();
    en = '1;
    m_axis_g_tready = 1'b1;
    m_axis_h_tready = 1'b1;
    for (int i = 0; i < NR; i++) push_pkt(i, 1);
    rst = 1'b1;
    drive();
    @(posedge clk);
    #1;
    model_reset();
    step();
    step();
    rst = 1'b0;
    acc_log.delete();
    step();
    checks++;
    if (acc_log.size() != 1 || acc_log[0] != 0) begin
      errors++; $display("FAIL first_grant got %0d exp 0", acc_log.size() ? acc_log[0] : -1);
    end
    drain();
  endtask
  task automatic test_wide_split();
    beat_t b;
    logic [GW-1:0] eg;
    logic [NW-1:0] eh;
    eg = {320{4'hA}};
    eh = {64{4'h5}};
    b.d = {eg, eh};
    b.l = 1'b1;
    srcq[1].push_back(b);
    step();
    checks += 4;
    if (m_axis_g_tvalid !== 1'b1 || m_axis_h_tvalid !== 1'b1) begin
      errors++; $display("FAIL split_valid got g=%b h=%b exp 1 1", m_axis_g_tvalid, m_axis_h_tvalid);
    end
    if (m_axis_g_tdata !== eg) begin
      errors++; $display("FAIL split_g got ..%h exp ..%h", m_axis_g_tdata[63:0], eg[63:0]);
    end
    if (m_axis_h_tdata !== eh) begin
      errors++; $display("FAIL split_h got ..%h exp ..%h", m_axis_h_tdata[63:0], eh[63:0]);
    end
    if (m_axis_h_tlast !== 1'b1) begin
      errors++; $display("FAIL split_last got %b exp 1", m_axis_h_tlast);
    end
    step();
    checks++;
    if (m_axis_g_tvalid !== 1'b0 || m_axis_h_tvalid !== 1'b0) begin
      errors++; $display("FAIL split_one_cycle got g=%b h=%b exp 0 0", m_axis_g_tvalid, m_axis_h_tvalid);
    end
  endtask
  task automatic test_round_robin();
    int exp_order[7] = '{0, 1, 2, 3, 4, 5, 0};
    int n = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NR; i++) push_pkt(i, 1);
    push_pkt(0, 1);
    acc_log.delete();
    while (acc_log.size() < 7 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (acc_log.size() != 7) begin
      errors++; $display("FAIL rr_count got %0d exp 7", acc_log.size());
    end else
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (acc_log[i] != exp_order[i]) begin
          errors++; $display("FAIL rr_order[%0d] got %0d exp %0d", i, acc_log[i], exp_order[i]);
        end
      end
    checks++;
    if (!srcs_empty()) begin
      errors++; $display("FAIL rr_leftover got nonempty exp empty");
    end
    drain();
  endtask
  task automatic test_packet_lock();
    int exp_order[5] = '{0, 0, 0, 0, 5};
    int n = 0;
    acc_log.delete();
    push_pkt(0, 4);
    step();
    push_pkt(5, 1);
    while (acc_log.size() < 5 && n < 30) begin
      step();
      n++;
    end
    checks++;
    if (acc_log.size() != 5) begin
      errors++; $display("FAIL lock_count got %0d exp 5", acc_log.size());
    end else
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (acc_log[i] != exp_order[i]) begin
          errors++; $display("FAIL lock_order[%0d] got %0d exp %0d", i, acc_log[i], exp_order[i]);
        end
      end
    drain();
  endtask
  task automatic test_backpressure();
    logic [WW-1:0] wd;
    push_pkt(3, 1);
    m_axis_h_tready = 1'b0;
    step();
    push_pkt(2, 1);
    wd = srcq[2][0].d;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (s_axis_tready !== '0 || m_axis_g_tvalid !== 1'b0) begin
        errors++; $display("FAIL bp_stall got tready=%b gv=%b exp 000 0", s_axis_tready, m_axis_g_tvalid);
      end
    end
    m_axis_h_tready = 1'b1;
    acc_log.delete();
    step();
    checks += 2;
    if (acc_log.size() != 1 || acc_log[0] != 2) begin
      errors++; $display("FAIL bp_accept got %0d beats exp 1 from 2", acc_log.size());
    end
    if (m_axis_g_tvalid !== 1'b1 || m_axis_g_tdata !== wd[WW-1:NW] || m_axis_h_tdata !== wd[NW-1:0]) begin
      errors++; $display("FAIL bp_data got gv=%b g=..%h exp 1 ..%h", m_axis_g_tvalid, m_axis_g_tdata[63:0], wd[NW+63:NW]);
    end
    drain();
  endtask
  task automatic test_reset_mid();
    acc_log.delete();
    push_pkt(1, 4);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_srcs();
    checks++;
    if (m_axis_g_tvalid !== 1'b0 || m_axis_h_tvalid !== 1'b0) begin
      errors++; $display("FAIL midrst_valid got g=%b h=%b exp 0 0", m_axis_g_tvalid, m_axis_h_tvalid);
    end
    push_pkt(4, 1);
    acc_log.delete();
    step();
    checks++;
    if (acc_log.size() != 1 || acc_log[0] != 4) begin
      errors++; $display("FAIL midrst_grant got %0d beats exp 1 from 4", acc_log.size());
    end
    drain();
  endtask
  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      int r;
      r = $urandom_range(0, NR - 1);
      if (srcq[r].size() < 4 && $urandom_range(0, 2) == 0) push_pkt(r, $urandom_range(1, 3));
      en = NR'($urandom);
      m_axis_g_tready = $urandom_range(0, 3) != 0;
      m_axis_h_tready = $urandom_range(0, 3) != 0;
      step();
    end
    drain();
  endtask
  initial begin
    rst = 1'b1;
    en = '0;
    m_axis_g_tready = 1'b0;
    m_axis_h_tready = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = '0; s_axis_tlast = '0;
    s_axis_256_tdata = '0; s_axis_256_tvalid = '0; s_axis_256_tlast = '0;
    model_reset();
    test_reset();
    test_wide_split();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
